// File: rtl/bram_pack_fifo_if.sv
// Handshake bundle for bram_pack_fifo: packer input side, FIFO output side and status.
interface bram_pack_fifo_if #(
    parameter int IN_W  = 32,
    parameter int RATIO = 2,
    parameter int DEPTH = 8
);
    localparam int OUT_W = IN_W * RATIO;

    logic [IN_W-1:0]            din;
    logic                       din_valid;
    logic                       din_ready;
    logic                       flush;
    logic [OUT_W-1:0]           dout;
    logic                       dout_valid;
    logic                       dout_ready;
    logic [$clog2(DEPTH):0]     count;
    logic [$clog2(RATIO):0]     lane_cnt;

    modport master (
        output din, din_valid, flush, dout_ready,
        input  din_ready, dout, dout_valid, count, lane_cnt
    );

    modport slave (
        input  din, din_valid, flush, dout_ready,
        output din_ready, dout, dout_valid, count, lane_cnt
    );
endinterface

// File: rtl/bram_pack_fifo.sv
// Packs RATIO narrow input words into one wide word and queues wide words in a
// first-word-fall-through FIFO; flush emits a partially packed word zero-padded.
module bram_pack_fifo #(
    parameter int IN_W      = 32,
    parameter int RATIO     = 2,
    parameter int DEPTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic            clk,
    input  logic            rst,
    bram_pack_fifo_if.slave bus
);
    localparam int OUT_W = IN_W * RATIO;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;
    localparam int LW    = $clog2(RATIO) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [LW-1:0] LAST = LW'(RATIO - 1);

    logic [OUT_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count_q;
    logic [LW-1:0]    lane_q, lane_idx;
    logic [OUT_W-1:0] pack_q, pack_next;
    logic             flush_pend;
    logic             not_full, din_rdy, xfer, pop, push, flush_req;

    always_comb begin
        not_full  = count_q < FULL;
        din_rdy   = not_full && !flush_pend;
        xfer      = bus.din_valid && din_rdy;
        pop       = (count_q != '0) && bus.dout_ready;
        lane_idx  = (MSB_FIRST != 0) ? (LAST - lane_q) : lane_q;
        pack_next = pack_q;
        if (xfer) begin
            pack_next = pack_q | (OUT_W'(bus.din) << (int'(lane_idx) * IN_W));
        end
        // A flush with an empty packer and no transfer has nothing to emit.
        flush_req = flush_pend || (bus.flush && ((lane_q != '0) || xfer));
        push      = (xfer && (lane_q == LAST)) || (flush_req && not_full);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            lane_q     <= '0;
            pack_q     <= '0;
            flush_pend <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr     <= wr_ptr + AW'(1);
                lane_q     <= '0;
                pack_q     <= '0;
                flush_pend <= 1'b0;
            end else begin
                if (xfer) begin
                    lane_q <= lane_q + LW'(1);
                end
                pack_q     <= pack_next;
                flush_pend <= flush_req;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is left uninitialised; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr] <= pack_next;
        end
    end

    assign bus.din_ready  = din_rdy;
    assign bus.dout_valid = (count_q != '0);
    assign bus.dout       = (count_q != '0) ? mem[rd_ptr] : '0;
    assign bus.count      = count_q;
    assign bus.lane_cnt   = lane_q;
endmodule

// File: doc/bram_pack_fifo.md
BRAM_PACK_FIFO -- requirements
Module: bram_pack_fifo

Interface
REQ-001 SHALL have parameter IN_W, default 32, input word width in bits.
REQ-002 SHALL have parameter RATIO, default 2, input words per output word (>=2); OUT_W = IN_W*RATIO.
REQ-003 SHALL have parameter DEPTH, default 8, output-word FIFO entries (power of two, >=2).
REQ-004 SHALL have parameter MSB_FIRST, default 1, meaning 1 = first input word lands in the top lane, 0 = first word lands in the bottom lane.
REQ-005 SHALL have port clk, input, 1, the single clock for all logic.
REQ-006 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-007 SHALL have port din, input, IN_W, input data word.
REQ-008 SHALL have port din_valid, input, 1, din is offered.
REQ-009 SHALL have port din_ready, output, 1, block accepts din this cycle.
REQ-010 SHALL have port flush, input, 1, one-cycle request to emit a partially packed word.
REQ-011 SHALL have port dout, output, OUT_W, head FIFO word, first-word-fall-through.
REQ-012 SHALL have port dout_valid, output, 1, dout holds a valid word.
REQ-013 SHALL have port dout_ready, input, 1, consumer takes dout this cycle.
REQ-014 SHALL have port count, output, clog2(DEPTH)+1, FIFO occupancy in output words.
REQ-015 SHALL have port lane_cnt, output, clog2(RATIO)+1, input words held in the packer, 0..RATIO-1.

Function
REQ-016 SHALL accept din on a rising clk edge when din_valid and din_ready are both 1 (transfer), and at no other time.
REQ-017 SHALL drive din_ready = 1 iff count < DEPTH and no flush is pending (combinational from registered state; no pop-through).
REQ-018 SHALL store transfer k (k = lane_cnt) in lane RATIO-1-k when MSB_FIRST = 1, and in lane k when MSB_FIRST = 0; lane i occupies bits [i*IN_W +: IN_W].
REQ-019 SHALL, on the transfer with lane_cnt = RATIO-1, push the completed word into the FIFO, set lane_cnt to 0 and clear the packer; the word is visible on dout, with dout_valid = 1, on the following cycle when the FIFO was empty.
REQ-020 SHALL, on any other transfer, increment lane_cnt by 1 and push nothing.
REQ-021 SHALL pop the head entry when dout_valid and dout_ready are both 1; dout_ready while dout_valid = 0 has no effect.
REQ-022 SHALL update count by +1 for a push alone, -1 for a pop alone, and 0 for a simultaneous push and pop.
REQ-023 SHALL keep read and write pointers at clog2(DEPTH) bits and wrap them modulo DEPTH.
REQ-024 SHALL latch flush into flush_pend when lane_cnt > 0 or a transfer occurs in the same cycle; flush with lane_cnt = 0 and no transfer SHALL be a no-op.
REQ-025 SHALL execute a pending flush on the first cycle with count < DEPTH: push the packer word with unfilled lanes zero, set lane_cnt to 0, clear flush_pend.
REQ-026 SHALL include a same-cycle transfer in the flushed word, at the lane given by the pre-transfer lane_cnt; if that transfer completes the word, the push SHALL be the normal REQ-019 push with no extra padded word.
REQ-027 SHALL drive dout to all zeros whenever dout_valid = 0.
REQ-028 SHALL never overwrite a FIFO entry: no push while count = DEPTH, no pop while count = 0.

Reset
REQ-029 SHALL, while rst = 1 on an edge, clear count, both pointers, lane_cnt, the packer register and flush_pend; rst SHALL take priority over a transfer, pop or flush in the same cycle.
REQ-030 SHALL, after reset, present din_ready = 1, dout_valid = 0, dout = 0, count = 0 and lane_cnt = 0; FIFO RAM contents need not be cleared.
REQ-031 SHALL, when rst is asserted mid-operation, discard the packed partial word and all FIFO contents.

Verification
REQ-032 SHALL cover this scenario (defaults): transfer 0xAAAA0001 then 0xBBBB0002 -> next cycle dout = 0xAAAA0001BBBB0002, dout_valid = 1, count = 1.
REQ-033 SHALL cover this scenario (MSB_FIRST = 0): transfer the same pair -> dout = 0xBBBB0002AAAA0001.
REQ-034 SHALL cover this scenario: with dout_ready = 0, transfer 16 words -> count = 8 and din_ready = 0; the 17th offer is not taken; one pop -> din_ready = 1 on the next cycle.
REQ-035 SHALL cover this scenario: transfer 0x12345678 then pulse flush -> dout = 0x1234567800000000, lane_cnt = 0.
REQ-036 SHALL cover this scenario: with count = 3, push and pop in the same cycle -> count stays 3 and data order is preserved across a pointer wrap.
REQ-037 SHALL cover this scenario: with count = 2 and lane_cnt = 1, assert rst for one cycle -> count = 0, lane_cnt = 0, dout_valid = 0, din_ready = 1.
